// File: rtl/follower_pkg.sv
// follower_pkg: shared command-framing constants and state encoding for the follower.
package follower_pkg;
    localparam logic CMD_IDLE    = 1'b0;
    localparam logic CMD_WAIT_LO = 1'b1;
    localparam int   CMD_TIMEOUT_DFLT = 104160;
    typedef enum logic {ST_IDLE = CMD_IDLE, ST_WAIT_LO = CMD_WAIT_LO} cmd_state_e;
endpackage

// File: rtl/cmd_tmo_timer.sv
// cmd_tmo_timer: saturating cycle counter flagging expiry at TIMEOUT-1 while enabled.
module cmd_tmo_timer #(
    parameter int TIMEOUT = 104160
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] cnt;
    assign expire = en && cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: pairs received UART bytes into 16-bit commands with sticky ready/overrun
// flags and abandons a half command after an inter-byte timeout.
module uart_cmd_ctrl
    import follower_pkg::*;
#(
    parameter int TIMEOUT = CMD_TIMEOUT_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        ovr,
    output logic        tmo
);
    cmd_state_e state;
    logic [7:0] hi_byte;
    logic       expire;
    assign clr_rx_rdy = rx_rdy;
    cmd_tmo_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_IDLE),
        .en     (state == ST_WAIT_LO),
        .expire (expire)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            hi_byte <= 8'h00;
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
            ovr     <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            tmo <= 1'b0;
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                ovr     <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (rx_rdy) begin
                    hi_byte <= rx_data;
                    state   <= ST_WAIT_LO;
                end
            end else if (rx_rdy) begin
                // a completion overrides a same-cycle clear of cmd_rdy
                cmd     <= {hi_byte, rx_data};
                cmd_rdy <= 1'b1;
                if (cmd_rdy && !clr_cmd_rdy)
                    ovr <= 1'b1;
                state   <= ST_IDLE;
            end else if (expire) begin
                tmo   <= 1'b1;
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized checks of uart_cmd_ctrl against a
// cycle-stamped reference model of the byte-pairing rules.
module tb_uart_cmd_ctrl;
    import follower_pkg::*;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, ovr, tmo;
    logic [15:0] cmd;
    logic        clr_rx_rdy_l, cmd_rdy_l, ovr_l, tmo_l;
    logic [15:0] cmd_l;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc = 0;
    bit          pend = 0;
    int          hi_cyc = 0;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_tmo = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .ovr(ovr), .tmo(tmo)
    );

    uart_cmd_ctrl dut_long (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy_l), .cmd(cmd_l), .cmd_rdy(cmd_rdy_l),
        .clr_cmd_rdy(clr_cmd_rdy), .ovr(ovr_l), .tmo(tmo_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a low byte completes if it arrives within TMO edges of its high byte;
    // with no byte by then, tmo shows on exactly the TMO-th edge after the high byte.
    task automatic model_edge(input logic rx, input logic [7:0] d, input logic clr);
        logic old_rdy;
        cyc++;
        m_tmo = 1'b0;
        old_rdy = m_rdy;
        if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        if (pend && rx) begin
            m_cmd = {m_hi, d};
            m_rdy = 1'b1;
            if (old_rdy && !clr) m_ovr = 1'b1;
            pend = 0;
        end else if (pend && cyc - hi_cyc == TMO) begin
            m_tmo = 1'b1;
            pend = 0;
        end else if (!pend && rx) begin
            pend = 1;
            m_hi = d;
            hi_cyc = cyc;
        end
    endtask

    task automatic step(input logic rx, input logic [7:0] d, input logic clr);
        @(negedge clk);
        rx_rdy = rx;
        rx_data = d;
        clr_cmd_rdy = clr;
        #1 chk("clr_rx_rdy", {31'b0, clr_rx_rdy}, {31'b0, rx});
        @(posedge clk);
        model_edge(rx, d, clr);
        #1;
        chk("cmd", {16'b0, cmd}, {16'b0, m_cmd});
        chk("cmd_rdy", {31'b0, cmd_rdy}, {31'b0, m_rdy});
        chk("ovr", {31'b0, ovr}, {31'b0, m_ovr});
        chk("tmo", {31'b0, tmo}, {31'b0, m_tmo});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        #1;
        chk("rst_cmd", {16'b0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'h0);
        chk("rst_ovr", {31'b0, ovr}, 32'h0);
        chk("rst_tmo", {31'b0, tmo}, 32'h0);
        chk("rst_clr_rx_rdy", {31'b0, clr_rx_rdy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pend = 0;
        m_cmd = 16'h0000;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        m_tmo = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Two bytes 100 cycles apart on the default-timeout instance
        step(1'b1, 8'hA5, 1'b0);
        idle(99);
        step(1'b1, 8'h3C, 1'b0);
        chk("long_cmd", {16'b0, cmd_l}, 32'h0000A53C);
        chk("long_cmd_rdy", {31'b0, cmd_rdy_l}, 32'h1);
        chk("long_tmo", {31'b0, tmo_l}, 32'h0);
        do_reset();

        // Silence after a high byte: tmo after TMO edges, then a fresh command
        step(1'b1, 8'h12, 1'b0);
        idle(TMO - 1);
        chk("pre_tmo", {31'b0, tmo}, 32'h0);
        step(1'b0, 8'h00, 1'b0);
        chk("tmo_pulse", {31'b0, tmo}, 32'h1);
        chk("tmo_rdy", {31'b0, cmd_rdy}, 32'h0);
        step(1'b1, 8'h56, 1'b0);
        chk("tmo_end", {31'b0, tmo}, 32'h0);
        step(1'b1, 8'h78, 1'b0);
        chk("cmd_5678", {16'b0, cmd}, 32'h00005678);

        // Low byte exactly at timer == TIMEOUT-1
        step(1'b1, 8'hC3, 1'b1);
        idle(TMO - 1);
        step(1'b1, 8'h9D, 1'b0);
        chk("edge_cmd", {16'b0, cmd}, 32'h0000C39D);
        chk("edge_tmo", {31'b0, tmo}, 32'h0);
        idle(TMO + 2);

        // Overrun, then clear
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        chk("ovr_cmd", {16'b0, cmd}, 32'h00002222);
        chk("ovr_set", {31'b0, ovr}, 32'h1);
        step(1'b0, 8'h00, 1'b1);
        chk("ovr_clr", {31'b0, ovr}, 32'h0);
        chk("rdy_clr", {31'b0, cmd_rdy}, 32'h0);

        // Clear coinciding with a completion
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hBE, 1'b0);
        step(1'b1, 8'hEF, 1'b1);
        chk("beef_cmd", {16'b0, cmd}, 32'h0000BEEF);
        chk("beef_rdy", {31'b0, cmd_rdy}, 32'h1);
        chk("beef_ovr", {31'b0, ovr}, 32'h0);

        // Reset mid-command drops the high byte
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hAA, 1'b0);
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        chk("rst_mid_cmd", {16'b0, cmd}, 32'h00000102);

        // Randomized traffic with silence runs and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                idle($urandom_range(TMO - 3, TMO + 3));
            else if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
